dlfloat_mac_seq: RTL

//  Sequencer for the DLFloat16 MAC datapath: assembles operand pairs from an 8-bit byte stream,

---
 rtl/dlfloat_mac_seq_pkg.sv | 10 +
 rtl/dlfloat_byte_asm.sv | 31 +++
 rtl/dlfloat_mac_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/dlfloat_mac_seq_pkg.sv
// dlfloat_mac_seq_pkg: DLFloat16 constants and sequencer state encoding
package dlfloat_mac_seq_pkg;
   localparam int          DLF_BIAS = 31;
   localparam logic [15:0] DLF_NAN  = 16'hFFFF;
   localparam logic [15:0] DLF_ZERO = 16'h0000;
   localparam logic [15:0] DLF_ONE  = 16'h3E00;
   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_ISSUE, S_DRAIN, S_OUT_LO, S_OUT_HI
   } state_t;
endpackage

// File: rtl/dlfloat_byte_asm.sv
// dlfloat_byte_asm: gathers a_lo, a_hi, b_lo from the byte stream; b_hi is forwarded live on the 4th byte
module dlfloat_byte_asm
   import dlfloat_mac_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic [15:0] a,
   output logic [7:0]  b_lo,
   output logic        done
);
   logic [1:0] byte_cnt;
   logic       acc;
   assign acc  = en & in_valid;
   assign done = acc & (byte_cnt == 2'd3);
   // store each accepted byte into its slot; the 2-bit count wraps 3->0 on its own
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= 2'd0;
         a        <= DLF_ZERO;
         b_lo     <= 8'd0;
      end else if (acc) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (byte_cnt == 2'd0) a[7:0]  <= in_data;
         if (byte_cnt == 2'd1) a[15:8] <= in_data;
         if (byte_cnt == 2'd2) b_lo    <= in_data;
      end
   end
endmodule

// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq: byte-stream sequencer driving the DLFloat16 MAC and serialising its result
module dlfloat_mac_seq
   import dlfloat_mac_seq_pkg::*;
#(
   parameter int LEN_W   = 4,
   parameter int MAC_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic             mac_en,
   output logic             mac_clr,
   input  logic [15:0]      mac_acc,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);
   state_t           state;
   logic [LEN_W-1:0] len, pair_cnt, pair_nxt, lat_cnt;
   logic [7:0]       res_hi;
   logic [15:0]      asm_a;
   logic [7:0]       asm_b_lo;
   logic             pair_done;

   assign pair_nxt = pair_cnt + LEN_W'(1);

   dlfloat_byte_asm u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (in_ready),
      .in_valid (in_valid),
      .in_data  (in_data),
      .a        (asm_a),
      .b_lo     (asm_b_lo),
      .done     (pair_done)
   );

   // sequencer FSM; every output is registered and set on the edge entering its state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len       <= '0;
         pair_cnt  <= '0;
         lat_cnt   <= '0;
         res_hi    <= 8'd0;
         in_ready  <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         mac_a     <= DLF_ZERO;
         mac_b     <= DLF_ZERO;
         out_data  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               len      <= cfg_len;
               pair_cnt <= '0;
               mac_clr  <= 1'b1;
               busy     <= 1'b1;
               state    <= S_CLR;
            end
            S_CLR: begin
               mac_clr  <= 1'b0;
               lat_cnt  <= '0;
               in_ready <= len != '0;
               state    <= len == '0 ? S_DRAIN : S_LOAD;
            end
            S_LOAD: if (pair_done) begin
               in_ready <= 1'b0;
               mac_en   <= 1'b1;
               mac_a    <= asm_a;
               mac_b    <= {in_data, asm_b_lo};
               state    <= S_ISSUE;
            end
            S_ISSUE: begin
               mac_en   <= 1'b0;
               pair_cnt <= pair_nxt;
               lat_cnt  <= '0;
               in_ready <= pair_nxt < len;
               state    <= pair_nxt < len ? S_LOAD : S_DRAIN;
            end
            S_DRAIN: if (lat_cnt == LEN_W'(MAC_LAT - 1)) begin
               out_data  <= mac_acc[7:0];
               res_hi    <= mac_acc[15:8];
               out_valid <= 1'b1;
               state     <= S_OUT_LO;
            end else lat_cnt <= lat_cnt + LEN_W'(1);
            S_OUT_LO: if (out_ready) begin
               out_data <= res_hi;
               state    <= S_OUT_HI;
            end
            S_OUT_HI: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
